// File: rtl/rlbp_code_capture_if.sv
// Control, comparator and FIFO-drain signals between the sequencer/readout side
// and the RLBP code capture block.
interface rlbp_code_capture_if #(
    parameter int NBITS = 12
);
    logic             start_i;
    logic             bit_valid_i;
    logic             abort_i;
    logic             cmp_i;
    logic             pop_i;
    logic             clr_ovf_i;
    logic [NBITS+3:0] data_o;
    logic             empty_o;
    logic             full_o;
    logic             overflow_o;
    logic             busy_o;
    logic             irq_o;

    modport master (
        output start_i, bit_valid_i, abort_i, cmp_i, pop_i, clr_ovf_i,
        input  data_o, empty_o, full_o, overflow_o, busy_o, irq_o
    );

    modport slave (
        input  start_i, bit_valid_i, abort_i, cmp_i, pop_i, clr_ovf_i,
        output data_o, empty_o, full_o, overflow_o, busy_o, irq_o
    );
endinterface

// File: rtl/rlbp_code_capture.sv
// RLBP back end: synchronizes the comparator, assembles NBITS decisions into a
// tagged code and queues completed codes in a first-word-fallthrough FIFO.
module rlbp_code_capture #(
    parameter int NBITS    = 12,
    parameter int DEPTH    = 8,
    parameter int SYNC_LAT = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    rlbp_code_capture_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SW = $clog2(SYNC_LAT + 1);
    localparam int W  = NBITS + 4;

    typedef enum logic [2:0] {IDLE, ACQ, SETTLE, CAPTURE, PUSH} state_t;

    state_t            state_q;
    logic              busy_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [SW-1:0]     settle_q;
    logic [NBITS-1:0]  shreg_q;
    logic [3:0]        tag_q;
    logic              cmp_meta_q, cmp_s_q;

    logic [W-1:0]      mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              empty, full, push_en, pop_en, wr_en, ovf_set;

    // cmp_i is asynchronous to the system clock
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= bus.cmp_i;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            settle_q  <= '0;
            shreg_q   <= '0;
            tag_q     <= 4'd0;
        end else if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= ACQ;
                    busy_q    <= 1'b1;
                end
                ACQ: if (bus.bit_valid_i) begin
                    settle_q <= SW'(SYNC_LAT - 1);
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (settle_q == '0) state_q <= CAPTURE;
                    else                settle_q <= settle_q - SW'(1);
                end
                CAPTURE: begin
                    shreg_q[bit_cnt_q] <= cmp_s_q;
                    if (bit_cnt_q == BW'(NBITS - 1)) begin
                        state_q <= PUSH;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                        state_q   <= ACQ;
                    end
                end
                PUSH: begin
                    // tag counts every completed code, even one dropped on overflow
                    tag_q   <= tag_q + 4'd1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_en = (state_q == PUSH) && !bus.abort_i;
    assign pop_en  = bus.pop_i && !empty;
    // a pop in the push cycle frees the slot, so a full FIFO still accepts
    assign wr_en   = push_en && (!full || pop_en);
    assign ovf_set = push_en && full && !pop_en;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en)  wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_set)            ovf_d = 1'b1;
        else if (bus.clr_ovf_i) ovf_d = 1'b0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= {tag_q, shreg_q};
    end

    assign bus.data_o     = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.empty_o    = empty;
    assign bus.full_o     = full;
    assign bus.overflow_o = ovf_q;
    assign bus.busy_o     = busy_q;
    assign bus.irq_o      = !empty;
endmodule

// File: tb/tb_rlbp_code_capture.sv
// Self-checking bench for rlbp_code_capture: directed scenarios plus a random
// phase, all compared each cycle against an event-time reference model.
module tb_rlbp_code_capture;
    localparam int NBITS    = 12;
    localparam int DEPTH    = 8;
    localparam int SYNC_LAT = 2;
    localparam int W        = NBITS + 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    always #5 wb_clk_i = ~wb_clk_i;

    rlbp_code_capture_if #(.NBITS(NBITS)) bus();

    rlbp_code_capture #(.NBITS(NBITS), .DEPTH(DEPTH), .SYNC_LAT(SYNC_LAT)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the code in progress as edge timestamps (capture
    // edge, push edge) rather than states; the FIFO is a plain queue.
    int               cyc = 0;
    bit               hist [0:131071];
    bit               m_busy;
    int               m_n, m_cap, m_push;
    logic [NBITS-1:0] m_code;
    logic [3:0]       m_tag;
    logic [W-1:0]     m_q [$];
    bit               m_ovf;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        bit do_push, set_ovf;
        if (wb_rst_i) begin
            m_busy = 0; m_n = 0; m_cap = -1; m_push = -1;
            m_code = '0; m_tag = 4'd0; m_ovf = 0;
            m_q.delete();
        end else begin
            cyc++;
            hist[cyc] = bus.cmp_i;
            do_push = 0;
            set_ovf = 0;
            if (bus.abort_i) begin
                m_busy = 0; m_cap = -1; m_push = -1;
            end else if (!m_busy) begin
                if (bus.start_i) begin
                    m_busy = 1; m_n = 0; m_code = '0; m_cap = -1; m_push = -1;
                end
            end else if (m_push == cyc) begin
                do_push = 1; m_busy = 0; m_push = -1;
            end else if (m_cap == cyc) begin
                // two synchronizer flops: the decision seen here left cmp_i two edges ago
                m_code[m_n] = hist[cyc-2];
                m_n++;
                m_cap = -1;
                if (m_n == NBITS) m_push = cyc + 1;
            end else if (m_cap < 0 && m_push < 0 && bus.bit_valid_i) begin
                m_cap = cyc + SYNC_LAT + 1;
            end
            if (bus.pop_i && m_q.size() > 0) void'(m_q.pop_front());
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_tag, m_code});
                else                    set_ovf = 1;
                m_tag = m_tag + 4'd1;
            end
            if (set_ovf)            m_ovf = 1;
            else if (bus.clr_ovf_i) m_ovf = 0;
        end
    end

    logic [W-1:0] exp_data;
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            exp_data = (m_q.size() > 0) ? m_q[0] : '0;
            check("data_o",     32'(bus.data_o),     32'(exp_data));
            check("empty_o",    32'(bus.empty_o),    32'(m_q.size() == 0));
            check("full_o",     32'(bus.full_o),     32'(m_q.size() == DEPTH));
            check("overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
            check("busy_o",     32'(bus.busy_o),     32'(m_busy));
            check("irq_o",      32'(bus.irq_o),      32'(m_q.size() != 0));
        end
    end

    task automatic reset_check(input string tag);
        check({tag, "_data"},  32'(bus.data_o),     32'h0);
        check({tag, "_empty"}, 32'(bus.empty_o),    32'h1);
        check({tag, "_full"},  32'(bus.full_o),     32'h0);
        check({tag, "_ovf"},   32'(bus.overflow_o), 32'h0);
        check({tag, "_busy"},  32'(bus.busy_o),     32'h0);
        check({tag, "_irq"},   32'(bus.irq_o),      32'h0);
    endtask

    // Reset lands mid-cycle, away from any clock edge, to exercise the async path.
    task automatic do_reset(input string tag);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1 reset_check(tag);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
    endtask

    // Returns at the negedge after the capture edge of the last bit (PUSH is next).
    task automatic send_code(input logic [NBITS-1:0] v, input int stop_at,
                             input bit do_abort, input bit extra);
        bus.start_i = 1'b1;
        @(negedge wb_clk_i);
        bus.start_i = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            if (i == stop_at) begin
                if (do_abort) begin
                    bus.abort_i = 1'b1;
                    @(negedge wb_clk_i);
                    bus.abort_i = 1'b0;
                end
                return;
            end
            bus.cmp_i = v[i];
            repeat (2) @(negedge wb_clk_i);
            bus.bit_valid_i = 1'b1;
            @(negedge wb_clk_i);
            bus.bit_valid_i = 1'b0;
            if (extra) begin
                bus.start_i = 1'b1;
                @(negedge wb_clk_i);
                bus.start_i = 1'b0;
                bus.bit_valid_i = 1'b1;
                @(negedge wb_clk_i);
                bus.bit_valid_i = 1'b0;
                @(negedge wb_clk_i);
            end else begin
                repeat (SYNC_LAT + 1) @(negedge wb_clk_i);
            end
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pop_i = 1'b1;
            @(negedge wb_clk_i);
            bus.pop_i = 1'b0;
        end
    endtask

    initial begin
        bus.start_i = 0; bus.bit_valid_i = 0; bus.abort_i = 0;
        bus.cmp_i = 0; bus.pop_i = 0; bus.clr_ovf_i = 0;
        repeat (3) @(negedge wb_clk_i);
        reset_check("rst0");
        wb_rst_i = 1'b0;

        // first code: timing of empty/busy around the push
        send_code(12'hA5C, -1, 0, 0);
        check("t1_empty_pre", 32'(bus.empty_o), 32'h1);
        check("t1_busy_pre",  32'(bus.busy_o),  32'h1);
        @(negedge wb_clk_i);
        check("t1_empty", 32'(bus.empty_o), 32'h0);
        check("t1_busy",  32'(bus.busy_o),  32'h0);
        check("t1_data",  32'(bus.data_o),  32'h0A5C);
        check("t1_irq",   32'(bus.irq_o),   32'h1);

        // fill past DEPTH, then drain and check tags
        do_reset("rst_t2");
        for (int k = 0; k < DEPTH + 1; k++) begin
            send_code(NBITS'($urandom), -1, 0, 0);
            repeat (2) @(negedge wb_clk_i);
            if (k == DEPTH - 1) begin
                check("t2_full8", 32'(bus.full_o),     32'h1);
                check("t2_ovf8",  32'(bus.overflow_o), 32'h0);
            end
        end
        check("t2_ovf9",  32'(bus.overflow_o), 32'h1);
        check("t2_full9", 32'(bus.full_o),     32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_tag", 32'(bus.data_o[W-1:NBITS]), 32'(i));
            pop_n(1);
        end
        check("t2_empty", 32'(bus.empty_o), 32'h1);
        bus.clr_ovf_i = 1'b1;
        @(negedge wb_clk_i);
        bus.clr_ovf_i = 1'b0;
        check("t2_clr", 32'(bus.overflow_o), 32'h0);

        // abort consumes no tag
        do_reset("rst_t3");
        send_code(NBITS'($urandom), 5, 1, 0);
        repeat (2) @(negedge wb_clk_i);
        send_code(12'hFFF, -1, 0, 0);
        @(negedge wb_clk_i);
        check("t3_data", 32'(bus.data_o), 32'h0FFF);

        // pop in the push cycle of a full FIFO
        do_reset("rst_t4");
        for (int k = 0; k < DEPTH; k++) begin
            send_code(NBITS'($urandom), -1, 0, 0);
            repeat (2) @(negedge wb_clk_i);
        end
        send_code(12'h3C3, -1, 0, 0);
        bus.pop_i = 1'b1;
        @(negedge wb_clk_i);
        bus.pop_i = 1'b0;
        check("t4_ovf",  32'(bus.overflow_o), 32'h0);
        check("t4_full", 32'(bus.full_o),     32'h1);
        pop_n(DEPTH - 1);
        check("t4_last", 32'(bus.data_o), 32'h83C3);

        // early strobes and start while busy are ignored
        do_reset("rst_t5");
        send_code(12'h5A3, -1, 0, 1);
        @(negedge wb_clk_i);
        check("t5_data", 32'(bus.data_o), 32'h05A3);

        // reset mid-code and mid-drain
        do_reset("rst_t6a");
        send_code(NBITS'($urandom), 6, 0, 0);
        do_reset("rst_t6b");
        for (int k = 0; k < 3; k++) begin
            send_code(NBITS'($urandom), -1, 0, 0);
            repeat (2) @(negedge wb_clk_i);
        end
        pop_n(1);
        do_reset("rst_t6c");
        send_code(12'h0F0, -1, 0, 0);
        @(negedge wb_clk_i);
        check("t6_data", 32'(bus.data_o), 32'h00F0);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.start_i     = ($urandom_range(19) == 0);
            bus.bit_valid_i = ($urandom_range(3) == 0);
            bus.abort_i     = ($urandom_range(199) == 0);
            bus.cmp_i       = $urandom_range(1);
            bus.pop_i       = ($urandom_range(5) == 0);
            bus.clr_ovf_i   = ($urandom_range(29) == 0);
            @(negedge wb_clk_i);
        end
        bus.start_i = 0; bus.bit_valid_i = 0; bus.abort_i = 0;
        bus.pop_i = 0; bus.clr_ovf_i = 0;
        repeat (2) @(negedge wb_clk_i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
